// File: rtl/pic_vec_wb.sv
// Wishbone programmable interrupt controller with per-line polarity, input sync and a priority vector.
// Define PIC_EDGE_DETECT_EN to add the EDGE register, edge latches and history flops.
module pic_vec_wb #(
   parameter int          NUM_IRQ     = 32,
   parameter int          SYNC_STAGES = 2,
   parameter logic [31:0] MASK_RESET  = 32'h0
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               cyc_i,
   input  logic               stb_i,
   input  logic [2:0]         adr_i,
   input  logic               we_i,
   input  logic [31:0]        dat_i,
   output logic [31:0]        dat_o,
   output logic               ack_o,
   output logic               int_o,
   input  logic [NUM_IRQ-1:0] irq_i
);

   logic [NUM_IRQ-1:0] w_irqSync;
   logic [NUM_IRQ-1:0] w_act;
   logic [NUM_IRQ-1:0] w_pending;
   logic [NUM_IRQ-1:0] w_status;
   logic [NUM_IRQ-1:0] r_mask;
   logic [NUM_IRQ-1:0] r_pol;
   logic [31:0]        w_edge32;
   logic [31:0]        w_vector;
   logic [31:0]        w_rdData;
   logic [4:0]         w_vecIdx;
   logic               w_access;
   logic               w_wr;
   logic               w_wrMask;
   logic               w_wrPol;

   generate
      if (SYNC_STAGES == 0) begin : g_noSync
         assign w_irqSync = irq_i;
      end else begin : g_sync
         logic [NUM_IRQ-1:0] r_syncChain [SYNC_STAGES];
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               for (int s = 0; s < SYNC_STAGES; s++) r_syncChain[s] <= '0;
            end else begin
               r_syncChain[0] <= irq_i;
               for (int s = 1; s < SYNC_STAGES; s++) r_syncChain[s] <= r_syncChain[s-1];
            end
         end
         assign w_irqSync = r_syncChain[SYNC_STAGES-1];
      end
   endgenerate

   // A new access is accepted only while ack is low, giving one ack per two cycles.
   assign w_access = cyc_i & stb_i & ~ack_o;
   assign w_wr     = w_access & we_i;
   assign w_wrMask = w_wr & (adr_i == 3'd1);
   assign w_wrPol  = w_wr & (adr_i == 3'd4);

   assign w_act = w_irqSync ^ r_pol;

`ifdef PIC_EDGE_DETECT_EN
   logic [NUM_IRQ-1:0] r_edge;
   logic [NUM_IRQ-1:0] r_latch;
   logic [NUM_IRQ-1:0] r_hist;
   logic [NUM_IRQ-1:0] w_rise;
   logic [NUM_IRQ-1:0] w_clr;
   logic [NUM_IRQ-1:0] w_ackHot;
   logic [NUM_IRQ-1:0] w_edgeFlip;
   logic               w_wrPend;
   logic               w_wrAck;
   logic               w_wrEdge;

   assign w_wrPend = w_wr & (adr_i == 3'd2);
   assign w_wrEdge = w_wr & (adr_i == 3'd3);
   assign w_wrAck  = w_wr & (adr_i == 3'd6);

   // Indices at or beyond NUM_IRQ simply match no bit, so they are ignored.
   always_comb begin
      w_ackHot = '0;
      for (int i = 0; i < NUM_IRQ; i++) w_ackHot[i] = (dat_i[4:0] == 5'(i));
   end

   assign w_rise     = w_act & ~r_hist;
   assign w_clr      = ({NUM_IRQ{w_wrPend}} & dat_i[NUM_IRQ-1:0]) | ({NUM_IRQ{w_wrAck}} & w_ackHot);
   assign w_edgeFlip = w_wrEdge ? (r_edge ^ dat_i[NUM_IRQ-1:0]) : '0;

   // Clear is applied before set so a coincident new edge survives; a mode change empties the latch.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_edge  <= '0;
         r_latch <= '0;
         r_hist  <= '0;
      end else begin
         r_hist  <= w_act;
         r_latch <= ((r_latch & ~w_clr) | w_rise) & r_edge & ~w_edgeFlip;
         if (w_wrEdge) r_edge <= dat_i[NUM_IRQ-1:0];
      end
   end

   assign w_pending = (r_edge & r_latch) | (~r_edge & w_act);
   assign w_edge32  = 32'(r_edge);
`else
   assign w_pending = w_act;
   assign w_edge32  = '0;
`endif

   assign w_status = w_pending & r_mask;

   always_comb begin
      w_vecIdx = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (w_status[i]) w_vecIdx = 5'(i);
      end
   end

   assign w_vector = {(|w_status), 26'b0, w_vecIdx};

   always_comb begin
      w_rdData = '0;
      case (adr_i)
         3'd0:    w_rdData = 32'(w_status);
         3'd1:    w_rdData = 32'(r_mask);
         3'd2:    w_rdData = 32'(w_pending);
         3'd3:    w_rdData = w_edge32;
         3'd4:    w_rdData = 32'(r_pol);
         3'd5:    w_rdData = w_vector;
         default: w_rdData = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ack_o  <= 1'b0;
         dat_o  <= '0;
         int_o  <= 1'b0;
         r_mask <= MASK_RESET[NUM_IRQ-1:0];
         r_pol  <= '0;
      end else begin
         ack_o <= w_access;
         dat_o <= (w_access & ~we_i) ? w_rdData : '0;
         int_o <= |w_status;
         if (w_wrMask) r_mask <= dat_i[NUM_IRQ-1:0];
         if (w_wrPol)  r_pol  <= dat_i[NUM_IRQ-1:0];
      end
   end

endmodule
